subterranean_hash_sequencer: RTL and testbench
==============================================

SUBTERRANEAN_HASH_SEQUENCER -- requirements
Module: subterranean_hash_sequencer

Interface
REQ-001 SHALL have one clock and an asynchronous active-low reset: clk  input  1  rising-edge clock; arstn  input  1  asynchronous active-low reset.
REQ-002 SHALL have start  input  1  one-cycle request to begin a hash; sampled only in IDLE.
REQ-003 SHALL have msg_empty  input  1  sampled with start; 1 = zero-length message.
REQ-004 SHALL have msg_data  input  8  message byte; msg_valid  input  1  byte present; msg_last  input  1  byte is final; msg_ready  output  1  byte accepted when msg_valid&msg_ready.
REQ-005 SHALL have core_start_operation  output  1; core_operation_type  output  4; core_buffer_in  output  32; core_buffer_in_size  output  2: command port to subterranean_simple_no_communication.
REQ-006 SHALL have core_buffer_out  input  32; core_free  input  1; core_finish  input  1: status from the core.
REQ-007 SHALL have digest  output  256  hash result; digest_valid  output  1  result held; busy  output  1  high outside IDLE/DONE.

Function
REQ-008 SHALL use states IDLE, INIT, GET_BYTE, ABS_BYTE, ABS_PAD, FINAL, BLANK, SQUEEZE, DONE.
REQ-009 Command issue SHALL occur only when core_free=1: core_start_operation high exactly one cycle; then ignore core_free for one cycle; the command completes on the first later cycle with core_free=1.
REQ-010 Outside the issue cycle, command outputs SHALL be type 4'h0, buffer_in 32'h0, size 2'b11.
REQ-011 IDLE/DONE + start SHALL clear digest_valid and go to INIT; start in any other state SHALL be ignored.
REQ-012 INIT SHALL issue type 4'h0, buffer_in 32'h0, size 2'b11; on completion go to FINAL if msg_empty was 1, else GET_BYTE.
REQ-013 GET_BYTE SHALL drive msg_ready=1 (0 in all other states), register byte and msg_last on handshake, go to ABS_BYTE.
REQ-014 ABS_BYTE SHALL issue type 4'h2, buffer_in {24'h000001, byte}, size 2'b01; then ABS_PAD.
REQ-015 ABS_PAD SHALL issue type 4'h2, buffer_in 32'h1, size 2'b00; then FINAL if registered last=1, else GET_BYTE.
REQ-016 FINAL SHALL issue 2 commands, BLANK 8 commands, each type 4'h2, buffer_in 32'h1, size 2'b00, counted by a 4-bit counter cleared on each state entry.
REQ-017 SQUEEZE SHALL issue 8 commands type 4'h7, buffer_in 32'h1, size 2'b11; on the core_finish cycle of each, digest <= {core_buffer_out, digest[255:32]}, so the first word ends in digest[31:0].
REQ-018 After the 8th capture SHALL enter DONE with digest_valid=1; digest stable until next start.
REQ-019 Total core commands for an N-byte message SHALL be 19+2N.
REQ-020 Messages SHALL be of unbounded length; no internal byte limit.

Reset
REQ-021 arstn low SHALL immediately force IDLE, counter 0, digest 0, digest_valid 0, busy 0, msg_ready 0, core_start_operation 0, command outputs per REQ-010, in any state including mid-command.
REQ-022 After reset release, the first start SHALL be honored only once core_free=1.

Configuration
REQ-023 Macro SUBTERRANEAN_HASH_ABORT_EN defined: input abort (1 bit) SHALL exist; abort=1 in any busy state SHALL let the in-flight command complete, then go to IDLE with digest_valid 0 and no further commands.
REQ-024 Macro undefined: no abort port; sequence always runs to DONE.

Verification
REQ-025 Empty message (start, msg_empty=1) -> exactly 19 commands, digest equals KAT Count=1 MD, digest_valid=1.
REQ-026 Single byte 0x00 with msg_last -> 21 commands, ABS_BYTE buffer_in 32'h00000100 size 2'b01, digest equals KAT Count=2 MD.
REQ-027 32-byte message 00..1F, msg_valid dropped 3 cycles between bytes -> msg_ready held, 83 commands, digest equals KAT Count=33 MD.
REQ-028 Core holding core_free=0 for 10 extra cycles on one command -> no start_operation issued during stall, digest unchanged vs. unstalled run.
REQ-029 arstn asserted during 4th squeeze -> all outputs at reset values same cycle; new hash of empty message then matches KAT Count=1.
REQ-030 With SUBTERRANEAN_HASH_ABORT_EN: abort during BLANK -> one more command completes, IDLE, digest_valid=0.

Source files
------------

// File: rtl/subterranean_hash_sequencer.sv
// Command sequencer that drives a Subterranean core through init, byte absorb, finalisation, blank and squeeze rounds.
// Optional abort input is enabled by defining SUBTERRANEAN_HASH_ABORT_EN.
`timescale 1ns/1ps
module subterranean_hash_sequencer (
    input  logic         clk,
    input  logic         arstn,
`ifdef SUBTERRANEAN_HASH_ABORT_EN
    input  logic         abort,
`endif
    input  logic         start,
    input  logic         msg_empty,
    input  logic [7:0]   msg_data,
    input  logic         msg_valid,
    input  logic         msg_last,
    output logic         msg_ready,
    output logic         core_start_operation,
    output logic [3:0]   core_operation_type,
    output logic [31:0]  core_buffer_in,
    output logic [1:0]   core_buffer_in_size,
    input  logic [31:0]  core_buffer_out,
    input  logic         core_free,
    input  logic         core_finish,
    output logic [255:0] digest,
    output logic         digest_valid,
    output logic         busy
);

    typedef enum logic [3:0] {
        IDLE, INIT, GET_BYTE, ABS_BYTE, ABS_PAD, FINAL, BLANK, SQUEEZE, DONE
    } state_t;

    // Each command walks ISSUE -> HOLD (core_free still stale) -> WAIT (completion).
    typedef enum logic [1:0] {
        C_ISSUE, C_HOLD, C_WAIT
    } phase_t;

    state_t         state_reg, state_next;
    phase_t         phase_reg, phase_next;
    logic [3:0]     cnt_reg, cnt_next;
    logic [7:0]     byte_reg, byte_next;
    logic           last_reg, last_next;
    logic           empty_reg, empty_next;
    logic [255:0]   digest_reg, digest_next;
    logic           dv_reg, dv_next;

    logic           cmd_state;
    logic           cmd_done;
    logic [3:0]     cmd_type;
    logic [31:0]    cmd_buf;
    logic [1:0]     cmd_size;

`ifdef SUBTERRANEAN_HASH_ABORT_EN
    logic           abort_reg, abort_next;
    logic           abort_hit;
`endif

    assign busy         = (state_reg != IDLE) && (state_reg != DONE);
    assign digest       = digest_reg;
    assign digest_valid = dv_reg;

    assign cmd_state = (state_reg == INIT)  || (state_reg == ABS_BYTE) ||
                       (state_reg == ABS_PAD) || (state_reg == FINAL) ||
                       (state_reg == BLANK) || (state_reg == SQUEEZE);
    assign cmd_done  = cmd_state && (phase_reg == C_WAIT) && core_free;

    always_comb begin
        cmd_type = 4'h2;
        cmd_buf  = 32'h1;
        cmd_size = 2'b00;
        case (state_reg)
            INIT: begin
                cmd_type = 4'h0;
                cmd_buf  = 32'h0;
                cmd_size = 2'b11;
            end
            ABS_BYTE: begin
                cmd_buf  = {24'h000001, byte_reg};
                cmd_size = 2'b01;
            end
            SQUEEZE: begin
                cmd_type = 4'h7;
                cmd_size = 2'b11;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_next           = state_reg;
        phase_next           = phase_reg;
        cnt_next             = cnt_reg;
        byte_next            = byte_reg;
        last_next            = last_reg;
        empty_next           = empty_reg;
        digest_next          = digest_reg;
        dv_next              = dv_reg;
        msg_ready            = 1'b0;
        core_start_operation = 1'b0;
        core_operation_type  = 4'h0;
        core_buffer_in       = 32'h0;
        core_buffer_in_size  = 2'b11;
`ifdef SUBTERRANEAN_HASH_ABORT_EN
        abort_next           = abort_reg;
        abort_hit            = busy && (abort || abort_reg);
`endif

        if (cmd_state) begin
            case (phase_reg)
                C_ISSUE: begin
                    if (core_free) begin
                        core_start_operation = 1'b1;
                        core_operation_type  = cmd_type;
                        core_buffer_in       = cmd_buf;
                        core_buffer_in_size  = cmd_size;
                        phase_next           = C_HOLD;
                    end
                end
                C_HOLD:  phase_next = C_WAIT;
                C_WAIT:  if (core_free) phase_next = C_ISSUE;
                default: phase_next = C_ISSUE;
            endcase
            if (state_reg == SQUEEZE && phase_reg != C_ISSUE && core_finish)
                digest_next = {core_buffer_out, digest_reg[255:32]};
        end

        case (state_reg)
            IDLE, DONE: begin
                if (start) begin
                    dv_next    = 1'b0;
                    empty_next = msg_empty;
                    state_next = INIT;
                    phase_next = C_ISSUE;
                    cnt_next   = 4'd0;
                end
            end
            GET_BYTE: begin
                msg_ready = 1'b1;
                if (msg_valid) begin
                    byte_next  = msg_data;
                    last_next  = msg_last;
                    state_next = ABS_BYTE;
                    cnt_next   = 4'd0;
                end
            end
            INIT: begin
                if (cmd_done) begin
                    state_next = empty_reg ? FINAL : GET_BYTE;
                    cnt_next   = 4'd0;
                end
            end
            ABS_BYTE: begin
                if (cmd_done) begin
                    state_next = ABS_PAD;
                    cnt_next   = 4'd0;
                end
            end
            ABS_PAD: begin
                if (cmd_done) begin
                    state_next = last_reg ? FINAL : GET_BYTE;
                    cnt_next   = 4'd0;
                end
            end
            FINAL: begin
                if (cmd_done) begin
                    if (cnt_reg == 4'd1) begin
                        state_next = BLANK;
                        cnt_next   = 4'd0;
                    end else begin
                        cnt_next = cnt_reg + 4'd1;
                    end
                end
            end
            BLANK: begin
                if (cmd_done) begin
                    if (cnt_reg == 4'd7) begin
                        state_next = SQUEEZE;
                        cnt_next   = 4'd0;
                    end else begin
                        cnt_next = cnt_reg + 4'd1;
                    end
                end
            end
            SQUEEZE: begin
                if (cmd_done) begin
                    if (cnt_reg == 4'd7) begin
                        state_next = DONE;
                        dv_next    = 1'b1;
                        cnt_next   = 4'd0;
                    end else begin
                        cnt_next = cnt_reg + 4'd1;
                    end
                end
            end
            default: begin
                state_next = IDLE;
                phase_next = C_ISSUE;
                cnt_next   = 4'd0;
            end
        endcase

`ifdef SUBTERRANEAN_HASH_ABORT_EN
        // An abort is remembered until no command is outstanding, then drops to IDLE.
        if (abort_hit) begin
            abort_next = 1'b1;
            if (state_reg == GET_BYTE || (cmd_state && phase_reg == C_ISSUE) || cmd_done) begin
                msg_ready            = 1'b0;
                core_start_operation = 1'b0;
                core_operation_type  = 4'h0;
                core_buffer_in       = 32'h0;
                core_buffer_in_size  = 2'b11;
                state_next           = IDLE;
                phase_next           = C_ISSUE;
                cnt_next             = 4'd0;
                dv_next              = 1'b0;
                abort_next           = 1'b0;
            end
        end
`endif
    end

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            state_reg  <= IDLE;
            phase_reg  <= C_ISSUE;
            cnt_reg    <= 4'd0;
            byte_reg   <= 8'h00;
            last_reg   <= 1'b0;
            empty_reg  <= 1'b0;
            digest_reg <= 256'h0;
            dv_reg     <= 1'b0;
`ifdef SUBTERRANEAN_HASH_ABORT_EN
            abort_reg  <= 1'b0;
`endif
        end else begin
            state_reg  <= state_next;
            phase_reg  <= phase_next;
            cnt_reg    <= cnt_next;
            byte_reg   <= byte_next;
            last_reg   <= last_next;
            empty_reg  <= empty_next;
            digest_reg <= digest_next;
            dv_reg     <= dv_next;
`ifdef SUBTERRANEAN_HASH_ABORT_EN
            abort_reg  <= abort_next;
`endif
        end
    end

endmodule

// File: tb/tb_subterranean_hash_sequencer.sv
// Randomized bench: a behavioural core model records every command and supplies squeeze words,
// expected command lists and digests are built from the message and a per-hash seed.
`timescale 1ns/1ps
module tb_subterranean_hash_sequencer;

    logic         clk = 1'b0;
    logic         arstn, start, msg_empty, msg_valid, msg_last, abort;
    logic [7:0]   msg_data;
    logic         msg_ready, core_start_operation;
    logic [3:0]   core_operation_type;
    logic [31:0]  core_buffer_in;
    logic [1:0]   core_buffer_in_size;
    logic [31:0]  core_buffer_out;
    logic         core_free, core_finish;
    logic [255:0] digest;
    logic         digest_valid, busy;

    always #5 clk = ~clk;

    subterranean_hash_sequencer dut (
        .clk                  (clk),
        .arstn                (arstn),
`ifdef SUBTERRANEAN_HASH_ABORT_EN
        .abort                (abort),
`endif
        .start                (start),
        .msg_empty            (msg_empty),
        .msg_data             (msg_data),
        .msg_valid            (msg_valid),
        .msg_last             (msg_last),
        .msg_ready            (msg_ready),
        .core_start_operation (core_start_operation),
        .core_operation_type  (core_operation_type),
        .core_buffer_in       (core_buffer_in),
        .core_buffer_in_size  (core_buffer_in_size),
        .core_buffer_out      (core_buffer_out),
        .core_free            (core_free),
        .core_finish          (core_finish),
        .digest               (digest),
        .digest_valid         (digest_valid),
        .busy                 (busy)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Core model state
    logic [37:0] cmd_q[$];
    logic [37:0] exp_q[$];
    logic [7:0]  msg_q[$];
    logic [37:0] cur_cmd;
    logic [31:0] seed;
    int hash_id  = 0;
    int cp       = 0;
    int rem      = 0;
    int kind     = 0;
    int sq_cnt   = 0;
    int if_sqk   = 0;
    int if_tag   = -1;
    bit if_sq    = 0;
    int stall_at = -1;
    int lat_max  = 3;
    bit prev_ready = 0;
    bit prev_valid = 0;

    function automatic logic [31:0] word_of(input logic [31:0] s, input int k);
        return (s * 32'h9E3779B9) ^ (32'(k + 1) * 32'h7F4A7C15) ^ 32'h5A5A0000;
    endfunction

    function automatic logic [255:0] exp_digest(input logic [31:0] s);
        logic [255:0] d;
        d = '0;
        for (int k = 0; k < 8; k++) d[32*k +: 32] = word_of(s, k);
        return d;
    endfunction

    // Core: issue cycle, one stale-free cycle, rem busy cycles, then a free+finish cycle.
    always @(negedge clk) begin
        core_finish     = 1'b0;
        core_buffer_out = $urandom;
        case (cp)
            1: begin kind = 1; core_free = 1'b1; cp = 2; end
            2: begin
                kind = 2; core_free = 1'b0; rem--;
                if (rem <= 0) cp = 3;
            end
            3: begin
                kind = 3; core_free = 1'b1; core_finish = 1'b1;
                if (if_sq && if_tag == hash_id) core_buffer_out = word_of(seed, if_sqk);
                cp = 0;
            end
            default: begin kind = 0; core_free = 1'b1; end
        endcase
        #1;
        cur_cmd = {core_operation_type, core_buffer_in, core_buffer_in_size};
        if (core_start_operation) begin
            check("issue_core_idle", 256'(kind), 256'(0));
            if (kind == 0) begin
                cmd_q.push_back(cur_cmd);
                if_sq  = (core_operation_type == 4'h7);
                if_tag = hash_id;
                if (if_sq) begin
                    if_sqk = sq_cnt;
                    sq_cnt++;
                end
                rem = $urandom_range(1, lat_max);
                if (cmd_q.size() == stall_at) rem += 10;
                cp = 1;
            end
        end else begin
            check("cmd_defaults", 256'(cur_cmd), 256'({4'h0, 32'h0, 2'b11}));
        end
        if (prev_ready && !prev_valid && arstn)
            check("ready_held", 256'(msg_ready), 256'(1));
        prev_ready = msg_ready;
        prev_valid = msg_valid;
    end

    task automatic begin_hash(input bit empty_msg, input int gap, input logic [31:0] sd);
        int n;
        int guard;
        n = empty_msg ? 0 : msg_q.size();
        exp_q.delete();
        exp_q.push_back({4'h0, 32'h0, 2'b11});
        for (int i = 0; i < n; i++) begin
            exp_q.push_back({4'h2, 24'h000001, msg_q[i], 2'b01});
            exp_q.push_back({4'h2, 32'h1, 2'b00});
        end
        repeat (10) exp_q.push_back({4'h2, 32'h1, 2'b00});
        repeat (8)  exp_q.push_back({4'h7, 32'h1, 2'b11});

        @(posedge clk); #2;
        hash_id++;
        cmd_q.delete();
        sq_cnt    = 0;
        seed      = sd;
        start     = 1'b1;
        msg_empty = empty_msg;
        @(posedge clk); #2;
        start     = 1'b0;
        msg_empty = 1'($urandom);
        @(negedge clk); #2;
        check("dv_cleared", 256'(digest_valid), 256'(0));
        @(posedge clk); #2;
        for (int i = 0; i < n; i++) begin
            msg_data  = msg_q[i];
            msg_last  = (i == n - 1);
            msg_valid = 1'b1;
            start     = 1'($urandom);
            guard     = 0;
            do begin
                @(negedge clk); #2;
                guard++;
            end while (!msg_ready && guard < 4000);
            check($sformatf("byte%0d_accept", i), 256'(msg_ready), 256'(1));
            if (!msg_ready) break;
            @(posedge clk); #2;
            if (gap > 0 || i == n - 1) begin
                msg_valid = 1'b0;
                start     = 1'b0;
                msg_data  = 8'($urandom);
                msg_last  = 1'($urandom);
                repeat (gap) begin @(posedge clk); #2; end
            end
        end
        msg_valid = 1'b0;
        start     = 1'b0;
    endtask

    task automatic finish_hash(input logic [31:0] sd, input int n, input string tag);
        int guard;
        guard = 0;
        do begin
            @(negedge clk); #2;
            guard++;
        end while (!digest_valid && guard < 6000);
        check({tag, "_digest_valid"}, 256'(digest_valid), 256'(1));
        check({tag, "_cmd_count"}, 256'(cmd_q.size()), 256'(19 + 2 * n));
        for (int i = 0; i < exp_q.size(); i++)
            if (i < cmd_q.size())
                check($sformatf("%s_cmd%0d", tag, i), 256'(cmd_q[i]), 256'(exp_q[i]));
        check({tag, "_digest"}, digest, exp_digest(sd));
        check({tag, "_busy_done"}, 256'(busy), 256'(0));
        check({tag, "_ready_done"}, 256'(msg_ready), 256'(0));
        repeat (6) @(negedge clk);
        #2;
        check({tag, "_digest_hold"}, digest, exp_digest(sd));
        $display("hash %s: %0d bytes, %0d commands, digest %0h", tag, n, cmd_q.size(), digest);
    endtask

    initial begin
        #800000;
        $display("FAIL watchdog: simulation time limit reached");
        n_fail++;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        int guard;
        int len;
        int gap;
        logic [31:0] sd;
        arstn     = 1'b0;
        start     = 1'b0;
        msg_empty = 1'b0;
        msg_valid = 1'b0;
        msg_last  = 1'b0;
        msg_data  = 8'h00;
        abort     = 1'b0;
        core_free = 1'b1;
        core_finish = 1'b0;
        core_buffer_out = 32'h0;
        repeat (3) @(posedge clk);
        #3;
        check("rst_busy", 256'(busy), 256'(0));
        check("rst_dv", 256'(digest_valid), 256'(0));
        check("rst_digest", digest, 256'h0);
        check("rst_ready", 256'(msg_ready), 256'(0));
        check("rst_start_op", 256'(core_start_operation), 256'(0));
        arstn = 1'b1;

        // Empty message
        msg_q.delete();
        begin_hash(1'b1, 0, 32'h000000E0);
        finish_hash(32'h000000E0, 0, "empty");

        // Single 0x00 byte
        msg_q.delete();
        msg_q.push_back(8'h00);
        begin_hash(1'b0, 0, 32'h00000001);
        finish_hash(32'h00000001, 1, "one_zero");
        check("abs_byte_zero", 256'(cmd_q[1]), 256'({4'h2, 32'h00000100, 2'b01}));

        // 32 bytes 00..1F with a three-cycle valid gap
        msg_q.delete();
        for (int i = 0; i < 32; i++) msg_q.push_back(8'(i));
        begin_hash(1'b0, 3, 32'h00000021);
        finish_hash(32'h00000021, 32, "ramp32");

        // Same message unstalled, then with one command stalled 10 extra cycles
        msg_q.delete();
        msg_q.push_back(8'hA5);
        msg_q.push_back(8'h3C);
        begin_hash(1'b0, 1, 32'h0BADF00D);
        finish_hash(32'h0BADF00D, 2, "nostall");
        stall_at = 4;
        begin_hash(1'b0, 1, 32'h0BADF00D);
        finish_hash(32'h0BADF00D, 2, "stall");
        stall_at = -1;

        // Reset during the 4th squeeze command, then a fresh empty hash
        msg_q.delete();
        begin_hash(1'b1, 0, 32'h00001234);
        guard = 0;
        do begin
            @(negedge clk); #2;
            guard++;
        end while (cmd_q.size() < 15 && guard < 4000);
        check("reach_squeeze4", 256'(cmd_q.size() >= 15), 256'(1));
        @(posedge clk); #3;
        arstn = 1'b0;
        #1;
        check("arst_busy", 256'(busy), 256'(0));
        check("arst_dv", 256'(digest_valid), 256'(0));
        check("arst_digest", digest, 256'h0);
        check("arst_ready", 256'(msg_ready), 256'(0));
        check("arst_start_op", 256'(core_start_operation), 256'(0));
        check("arst_cmd", 256'({core_operation_type, core_buffer_in, core_buffer_in_size}),
              256'({4'h0, 32'h0, 2'b11}));
        repeat (3) @(posedge clk);
        #3;
        arstn = 1'b1;
        begin_hash(1'b1, 0, 32'h000000E1);
        finish_hash(32'h000000E1, 0, "post_reset");

        // Randomized messages, gaps and core latencies
        for (int r = 0; r < 6; r++) begin
            len = $urandom_range(0, 6);
            gap = $urandom_range(0, 3);
            lat_max = $urandom_range(1, 5);
            sd = $urandom;
            msg_q.delete();
            for (int i = 0; i < len; i++) msg_q.push_back(8'($urandom));
            begin_hash(len == 0, gap, sd);
            finish_hash(sd, len, $sformatf("rand%0d", r));
        end

`ifdef SUBTERRANEAN_HASH_ABORT_EN
        // Abort after the 3rd blank command is issued: it completes, nothing more follows
        msg_q.delete();
        msg_q.push_back(8'h11);
        msg_q.push_back(8'h22);
        begin_hash(1'b0, 0, 32'h0000AB00);
        guard = 0;
        do begin
            @(negedge clk); #2;
            guard++;
        end while (cmd_q.size() < 10 && guard < 4000);
        @(posedge clk); #2;
        abort = 1'b1;
        @(posedge clk); #2;
        abort = 1'b0;
        guard = 0;
        do begin
            @(negedge clk); #2;
            guard++;
        end while (busy && guard < 200);
        check("abort_idle", 256'(busy), 256'(0));
        check("abort_cmds", 256'(cmd_q.size()), 256'(10));
        check("abort_dv", 256'(digest_valid), 256'(0));
        repeat (20) @(negedge clk);
        #2;
        check("abort_quiet", 256'(cmd_q.size()), 256'(10));
        $display("abort: %0d commands issued", cmd_q.size());
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
